switch_debouncer: RTL

Input-conditioning stage that sits directly upstream of the lab's D-latch. It takes a raw, bouncing push-button or slide-switch level, synchronises it to `clk` and filters it. It then presents a clean, stable level `d_out` that drives the latch's `d` input. It also counts rejected glitches for lab observation and can optionally emit single-cycle edge pulses.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/switch_debouncer.sv | 118 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer and its synchroniser.
// The optional edge-pulse outputs are enabled by defining DEBOUNCE_EDGE_EN.
package debounce_pkg;

    localparam int unsigned GLITCH_W = 8;
    localparam int unsigned CNT_W    = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    // Observation bundle so checkers can see the filter's internal progress.
    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] cnt;
    } dbg_t;

    function automatic logic [GLITCH_W-1:0] glitch_inc(input logic [GLITCH_W-1:0] v);
        return (v == GLITCH_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with an asynchronous active-low clear to a fixed level.
// Reused for the latch's asynchronous preset/clear inputs.
module sync_2ff #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic ff1;
    logic ff2;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ff1 <= RESET_LEVEL;
            ff2 <= RESET_LEVEL;
        end else begin
            ff1 <= d;
            ff2 <= ff1;
        end
    end

    assign q = ff2;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and filters a bouncing switch level into a clean d_out for the latch.
// Define DEBOUNCE_EDGE_EN to add registered one-cycle rise_pulse/fall_pulse outputs.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                sw_raw,
    output logic                d_out,
    output logic [GLITCH_W-1:0] glitch_cnt,
`ifdef DEBOUNCE_EDGE_EN
    output logic                rise_pulse,
    output logic                fall_pulse,
`endif
    output dbg_t                dbg
);

    localparam logic [CNT_W-1:0] STABLE_LIM  = CNT_W'(STABLE_CYCLES);
    localparam state_t           RESET_STATE = RESET_LEVEL ? ST_HI : ST_LO;

    logic             sw_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_2ff #(
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk     (clk),
        .clear_n (clear_n),
        .d       (sw_raw),
        .q       (sw_sync)
    );

    // cnt counts synchronised cycles at the new level, including the entry cycle,
    // so acceptance happens once the level has been seen STABLE_CYCLES+1 times.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= RESET_STATE;
            cnt        <= '0;
            glitch_cnt <= '0;
            d_out      <= RESET_LEVEL;
`ifdef DEBOUNCE_EDGE_EN
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_EDGE_EN
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
`endif
            case (state)
                ST_LO: begin
                    if (sw_sync) begin
                        state <= WAIT_HI;
                        cnt   <= 8'd1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (sw_sync) begin
                        if (cnt == STABLE_LIM) begin
                            state <= ST_HI;
                            d_out <= 1'b1;
                            cnt   <= '0;
`ifdef DEBOUNCE_EDGE_EN
                            rise_pulse <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state      <= ST_LO;
                        cnt        <= '0;
                        glitch_cnt <= glitch_inc(glitch_cnt);
                    end
                end
                ST_HI: begin
                    if (!sw_sync) begin
                        state <= WAIT_LO;
                        cnt   <= 8'd1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (!sw_sync) begin
                        if (cnt == STABLE_LIM) begin
                            state <= ST_LO;
                            d_out <= 1'b0;
                            cnt   <= '0;
`ifdef DEBOUNCE_EDGE_EN
                            fall_pulse <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state      <= ST_HI;
                        cnt        <= '0;
                        glitch_cnt <= glitch_inc(glitch_cnt);
                    end
                end
                default: begin
                    state <= RESET_STATE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign dbg.state = state;
    assign dbg.cnt   = cnt;

endmodule
